comm_frame_link: RTL

COMM_FRAME_LINK -- requirements
Module: comm_frame_link

---
 rtl/comm_pkg.sv | 31 +++
 rtl/comm_frame_rx.sv | 120 ++++++++++++
 rtl/comm_frame_link.sv | 143 ++++++++++++++
 3 files changed

// File: rtl/comm_pkg.sv
// Shared types and helpers for the serial frame link: FSM state encodings,
// frame length and parity.
package comm_pkg;

    typedef enum logic [2:0] {
        TX_IDLE,
        TX_START,
        TX_DATA,
        TX_PARITY,
        TX_STOP
    } tx_state_t;

    typedef enum logic [2:0] {
        RX_IDLE,
        RX_START,
        RX_DATA,
        RX_PARITY,
        RX_STOP
    } rx_state_t;

    // Bits per frame: start + data + optional parity + stop.
    function automatic int frame_len(input int data_w, input int parity_en);
        return data_w + ((parity_en != 0) ? 1 : 0) + 2;
    endfunction

    // Even parity over a word; callers zero-extend narrower words.
    function automatic logic parity_of(input logic [31:0] word);
        return ^word;
    endfunction

endpackage

// File: rtl/comm_frame_rx.sv
// Serial frame receiver: falling-edge start detection, mid-bit sampling,
// parity and stop-bit checking, one-cycle out_valid per completed frame.
//
// state     | meaning
// ----------+------------------------------------------------------------
// RX_IDLE   | line idle, waiting for a 1-to-0 transition
// RX_START  | inside start bit, mid-sample must be 0 or it is a false start
// RX_DATA   | sampling DATA_W data bits, LSB first
// RX_PARITY | sampling the parity bit (only reached when PARITY_EN=1)
// RX_STOP   | sampling the stop bit, then committing results next cycle
module comm_frame_rx
    import comm_pkg::*;
#(
    parameter int DATA_W    = 8,
    parameter int CLK_DIV   = 4,
    parameter int PARITY_EN = 1
) (
    input  logic              sysclk,
    input  logic              reset,
    input  logic              line,
    output logic [DATA_W-1:0] data_out,
    output logic              out_valid,
    output logic              err_parity,
    output logic              err_frame
);

    localparam int DIV_W = $clog2(CLK_DIV);
    localparam int BIT_W = $clog2(DATA_W);
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);
    localparam logic [DIV_W-1:0] DIV_MID  = DIV_W'(CLK_DIV / 2);
    localparam logic [BIT_W-1:0] BIT_LAST = BIT_W'(DATA_W - 1);

    rx_state_t         state;
    logic [DIV_W-1:0]  div_cnt;
    logic [BIT_W-1:0]  bit_cnt;
    logic [DATA_W-1:0] shift;
    logic              par_bit;
    logic              stop_bit;
    logic              stop_seen;
    logic              line_prev;
    logic              mid;
    logic              fall;

    assign mid  = (div_cnt == DIV_MID);
    assign fall = line_prev & ~line;

    // Receive FSM with divider and bit counters; outputs are registered.
    always_ff @(posedge sysclk or negedge reset) begin
        if (!reset) begin
            state      <= RX_IDLE;
            div_cnt    <= '0;
            bit_cnt    <= '0;
            shift      <= '0;
            par_bit    <= 1'b0;
            stop_bit   <= 1'b0;
            stop_seen  <= 1'b0;
            line_prev  <= 1'b1;
            data_out   <= '0;
            out_valid  <= 1'b0;
            err_parity <= 1'b0;
            err_frame  <= 1'b0;
        end else begin
            line_prev <= line;
            out_valid <= 1'b0;

            // The detection edge already lies one cycle into the start bit,
            // so the divider restarts at 1 to keep sampling at CLK_DIV/2.
            if (state == RX_IDLE)
                div_cnt <= fall ? DIV_W'(1) : '0;
            else if (div_cnt == DIV_LAST)
                div_cnt <= '0;
            else
                div_cnt <= div_cnt + DIV_W'(1);

            case (state)
                RX_IDLE: begin
                    stop_seen <= 1'b0;
                    if (fall)
                        state <= RX_START;
                end
                RX_START: begin
                    if (mid)
                        state <= line ? RX_IDLE : RX_DATA;
                end
                RX_DATA: begin
                    if (mid) begin
                        shift <= {line, shift[DATA_W-1:1]};
                        if (bit_cnt == BIT_LAST) begin
                            bit_cnt <= '0;
                            state   <= (PARITY_EN != 0) ? RX_PARITY : RX_STOP;
                        end else begin
                            bit_cnt <= bit_cnt + BIT_W'(1);
                        end
                    end
                end
                RX_PARITY: begin
                    if (mid) begin
                        par_bit <= line;
                        state   <= RX_STOP;
                    end
                end
                RX_STOP: begin
                    if (stop_seen) begin
                        data_out   <= shift;
                        err_parity <= (PARITY_EN != 0) ? (par_bit ^ parity_of(32'(shift))) : 1'b0;
                        err_frame  <= ~stop_bit;
                        out_valid  <= 1'b1;
                        stop_seen  <= 1'b0;
                        state      <= RX_IDLE;
                    end else if (mid) begin
                        stop_bit  <= line;
                        stop_seen <= 1'b1;
                    end
                end
                default: state <= RX_IDLE;
            endcase
        end
    end

endmodule

// File: rtl/comm_frame_link.sv
// Serial frame link: transmitter FSM, rx_line synchroniser, loopback mux and
// the receiver instance.
//
// state     | meaning
// ----------+------------------------------------------------------------
// TX_IDLE   | line high, data_ready high, waiting for data_valid
// TX_START  | driving the start bit (0)
// TX_DATA   | driving DATA_W data bits, LSB first
// TX_PARITY | driving the even-parity bit (only reached when PARITY_EN=1)
// TX_STOP   | driving the stop bit (1), then back to TX_IDLE
module comm_frame_link
    import comm_pkg::*;
#(
    parameter int DATA_W    = 8,
    parameter int CLK_DIV   = 4,
    parameter int PARITY_EN = 1,
    parameter int LOOPBACK  = 1
) (
    input  logic              sysclk,
    input  logic              reset,
    input  logic [DATA_W-1:0] data_in,
    input  logic              data_valid,
    output logic              data_ready,
    output logic              tx_line,
    input  logic              rx_line,
    output logic [DATA_W-1:0] data_out,
    output logic              out_valid,
    output logic              err_parity,
    output logic              err_frame
);

    localparam int DIV_W = $clog2(CLK_DIV);
    localparam int BIT_W = $clog2(DATA_W);
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);
    localparam logic [BIT_W-1:0] BIT_LAST = BIT_W'(DATA_W - 1);

    tx_state_t         tx_state;
    logic [DIV_W-1:0]  tx_div;
    logic [BIT_W-1:0]  tx_bit;
    logic [DATA_W-1:0] tx_shift;
    logic              tx_par;
    logic              tx_div_end;
    logic [1:0]        rx_sync;
    logic              rx_src;

    assign tx_div_end = (tx_div == DIV_LAST);

    // Transmit FSM; tx_line is registered so the start bit follows acceptance.
    always_ff @(posedge sysclk or negedge reset) begin
        if (!reset) begin
            tx_state   <= TX_IDLE;
            tx_div     <= '0;
            tx_bit     <= '0;
            tx_shift   <= '0;
            tx_par     <= 1'b0;
            tx_line    <= 1'b1;
            data_ready <= 1'b0;
        end else begin
            if (tx_state == TX_IDLE || tx_div_end)
                tx_div <= '0;
            else
                tx_div <= tx_div + DIV_W'(1);

            case (tx_state)
                TX_IDLE: begin
                    tx_line <= 1'b1;
                    if (data_valid && data_ready) begin
                        tx_shift   <= data_in;
                        tx_par     <= parity_of(32'(data_in));
                        tx_line    <= 1'b0;
                        data_ready <= 1'b0;
                        tx_state   <= TX_START;
                    end else begin
                        data_ready <= 1'b1;
                    end
                end
                TX_START: begin
                    if (tx_div_end) begin
                        tx_line  <= tx_shift[0];
                        tx_state <= TX_DATA;
                    end
                end
                TX_DATA: begin
                    if (tx_div_end) begin
                        if (tx_bit == BIT_LAST) begin
                            tx_bit <= '0;
                            if (PARITY_EN != 0) begin
                                tx_line  <= tx_par;
                                tx_state <= TX_PARITY;
                            end else begin
                                tx_line  <= 1'b1;
                                tx_state <= TX_STOP;
                            end
                        end else begin
                            tx_bit   <= tx_bit + BIT_W'(1);
                            tx_shift <= tx_shift >> 1;
                            tx_line  <= tx_shift[1];
                        end
                    end
                end
                TX_PARITY: begin
                    if (tx_div_end) begin
                        tx_line  <= 1'b1;
                        tx_state <= TX_STOP;
                    end
                end
                TX_STOP: begin
                    if (tx_div_end) begin
                        data_ready <= 1'b1;
                        tx_state   <= TX_IDLE;
                    end
                end
                default: tx_state <= TX_IDLE;
            endcase
        end
    end

    // Two-flop synchroniser for the external line; idles high like the line.
    always_ff @(posedge sysclk or negedge reset) begin
        if (!reset)
            rx_sync <= 2'b11;
        else
            rx_sync <= {rx_sync[0], rx_line};
    end

    // Loopback takes tx_line directly: it is already in this clock domain.
    assign rx_src = (LOOPBACK != 0) ? tx_line : rx_sync[1];

    comm_frame_rx #(
        .DATA_W    (DATA_W),
        .CLK_DIV   (CLK_DIV),
        .PARITY_EN (PARITY_EN)
    ) u_rx (
        .sysclk     (sysclk),
        .reset      (reset),
        .line       (rx_src),
        .data_out   (data_out),
        .out_valid  (out_valid),
        .err_parity (err_parity),
        .err_frame  (err_frame)
    );

endmodule
